// File: rtl/fp_accum.sv
// fp_accum: streaming fixed-point block accumulator with requantisation and saturation.
// Optional round-half-up on right shifts when FP_ACCUM_ROUND_EN is defined.
module fp_accum #(
  parameter int I_IN  = 2,
  parameter int F_IN  = 14,
  parameter int I_OUT = 2,
  parameter int F_OUT = 14,
  parameter int GUARD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [I_IN+F_IN-1:0]   in_data,
  input  logic                   in_signed,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [I_OUT+F_OUT-1:0] out_data,
  output logic                   out_signed,
  output logic [GUARD:0]         out_len,
  output logic                   overflow,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int IN_W  = I_IN + F_IN;
  localparam int OUT_W = I_OUT + F_OUT;
  localparam int ACC_W = IN_W + GUARD + 1;
  localparam int SH_L  = F_OUT >= F_IN ? F_OUT - F_IN : 0;
  localparam int SH_R  = F_IN > F_OUT ? F_IN - F_OUT : 0;
  localparam int W     = ACC_W + SH_L + OUT_W + 2;
  localparam logic signed [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] S_HI = (ONE <<< (OUT_W-1)) - ONE;
  localparam logic signed [W-1:0] S_LO = -(ONE <<< (OUT_W-1));
  localparam logic signed [W-1:0] U_HI = (ONE <<< OUT_W) - ONE;
  localparam logic [GUARD:0] CNT_MAX = {1'b0, {GUARD{1'b1}}};
  localparam logic [GUARD:0] CNT_ONE = {{GUARD{1'b0}}, 1'b1};
  localparam logic [1:0] S_ACC  = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  logic [1:0] state;
  logic [ACC_W-1:0] acc, smp;
  logic [GUARD:0] count;
  logic sgn, first, smp_sgn, close, ovf;
  logic signed [W-1:0] ext, scaled, hi, lo;
  logic [OUT_W-1:0] res;
  assign in_ready  = state == S_ACC;
  assign out_valid = state == S_OUT;
  assign first     = count == '0;
  assign smp_sgn   = first ? in_signed : sgn;
  assign smp       = smp_sgn ? {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data} : {{(ACC_W-IN_W){1'b0}}, in_data};
  // the length cap closes on the beat that brings count to 2^GUARD
  assign close     = in_last || count == CNT_MAX;
  always_comb begin
    ext = {{(W-ACC_W){acc[ACC_W-1]}}, acc};
`ifdef FP_ACCUM_ROUND_EN
    scaled = ((ext + ((ONE <<< SH_R) >>> 1)) <<< SH_L) >>> SH_R;
`else
    scaled = (ext <<< SH_L) >>> SH_R;
`endif
    hi  = sgn ? S_HI : U_HI;
    lo  = sgn ? S_LO : '0;
    ovf = scaled > hi || scaled < lo;
    res = scaled > hi ? hi[OUT_W-1:0] : scaled < lo ? lo[OUT_W-1:0] : scaled[OUT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_ACC;
      acc        <= '0;
      count      <= '0;
      sgn        <= 1'b0;
      out_data   <= '0;
      out_signed <= 1'b0;
      out_len    <= '0;
      overflow   <= 1'b0;
    end else if (state == S_ACC && in_valid) begin
      acc   <= first ? smp : acc + smp;
      count <= count + CNT_ONE;
      sgn   <= smp_sgn;
      state <= close ? S_CONV : S_ACC;
    end else if (state == S_CONV) begin
      out_data   <= res;
      out_signed <= sgn;
      out_len    <= count;
      overflow   <= ovf;
      state      <= S_OUT;
    end else if (state == S_OUT && out_ready) begin
      acc   <= '0;
      count <= '0;
      state <= S_ACC;
    end
  end
endmodule

// File: tb/tb_fp_accum.sv
// tb_fp_accum: directed bench for fp_accum; a second instance with F_OUT=12 covers right-shift requantisation.
module tb_fp_accum;
  logic clk = 0, rst_n = 0;
  logic [15:0] in_data = '0;
  logic in_signed = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_signed, overflow, out_valid;
  logic [15:0] out_data;
  logic [4:0] out_len;
  logic in_ready12, out_signed12, overflow12, out_valid12;
  logic [13:0] out_data12;
  logic [4:0] out_len12;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  fp_accum dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_signed(out_signed),
    .out_len(out_len), .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  fp_accum #(.F_OUT(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready12), .out_data(out_data12), .out_signed(out_signed12),
    .out_len(out_len12), .overflow(overflow12), .out_valid(out_valid12), .out_ready(1'b1)
  );

  task automatic send(input logic [15:0] d, input logic s, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errs++;
      $display("FAIL send_wait: in_ready=%b required 1", in_ready);
    end
    in_data = d; in_signed = s; in_last = l; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic ack();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++;
    if ({out_valid, out_data, out_len, overflow, out_signed, in_ready} !== {1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL reset_state: got v=%b d=%h len=%0d ov=%b s=%b rdy=%b required v=0 d=0 len=0 ov=0 s=0 rdy=1",
               out_valid, out_data, out_len, overflow, out_signed, in_ready);
    end
    rst_n = 1;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_unsigned();
    for (int i = 0; i < 4; i++) send(16'd4096, 1'b0, i == 3);
    @(negedge clk);
    vecs++;
    if ({out_valid, in_ready} !== 2'b00) begin errs++; $display("FAIL conv_cycle: got v=%b rdy=%b required 0 0", out_valid, in_ready); end
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL valid_latency: got %b required 1", out_valid); end
    vecs++;
    if ({out_data, out_len, overflow, out_signed} !== {16'd16384, 5'd4, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL unsigned_sum: got d=%0d len=%0d ov=%b s=%b required d=16384 len=4 ov=0 s=0", out_data, out_len, overflow, out_signed);
    end
    ack();
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL unsigned_ack: got %b required 0", out_valid); end
  endtask

  task automatic test_signed_sat();
    send(16'hA000, 1'b1, 1'b0);
    send(16'hC000, 1'b0, 1'b1);
    wait_valid();
    vecs++;
    if ({out_valid, out_data, overflow, out_signed, out_len} !== {1'b1, 16'h8000, 1'b1, 1'b1, 5'd2}) begin
      errs++;
      $display("FAIL signed_sat: got v=%b d=%h ov=%b s=%b len=%0d required v=1 d=8000 ov=1 s=1 len=2", out_valid, out_data, overflow, out_signed, out_len);
    end
    ack();
  endtask

  task automatic test_unsigned_sat();
    for (int i = 0; i < 3; i++) send(16'd24576, 1'b0, i == 2);
    wait_valid();
    vecs++;
    if ({out_valid, out_data, overflow, out_signed, out_len} !== {1'b1, 16'hFFFF, 1'b1, 1'b0, 5'd3}) begin
      errs++;
      $display("FAIL unsigned_sat: got v=%b d=%h ov=%b s=%b len=%0d required v=1 d=ffff ov=1 s=0 len=3", out_valid, out_data, overflow, out_signed, out_len);
    end
    ack();
  endtask

  task automatic test_len_cap();
    for (int i = 0; i < 16; i++) send(16'd1, 1'b1, 1'b0);
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL cap_close: in_ready=%b required 0", in_ready); end
    wait_valid();
    vecs++;
    if ({out_valid, out_data, out_len, overflow, out_signed} !== {1'b1, 16'd16, 5'd16, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL cap_result: got v=%b d=%0d len=%0d ov=%b s=%b required v=1 d=16 len=16 ov=0 s=1", out_valid, out_data, out_len, overflow, out_signed);
    end
    ack();
    send(16'd1, 1'b1, 1'b1);
    wait_valid();
    vecs++;
    if ({out_valid, out_data, out_len} !== {1'b1, 16'd1, 5'd1}) begin
      errs++;
      $display("FAIL cap_next_block: got v=%b d=%0d len=%0d required v=1 d=1 len=1", out_valid, out_data, out_len);
    end
    ack();
  endtask

  task automatic test_f_out12();
    logic [13:0] exp12;
`ifdef FP_ACCUM_ROUND_EN
    exp12 = 14'd1;
`else
    exp12 = 14'd0;
`endif
    send(16'd3, 1'b0, 1'b1);
    wait_valid();
    vecs++;
    if ({out_data, out_len} !== {16'd3, 5'd1}) begin
      errs++;
      $display("FAIL f14_single: got d=%0d len=%0d required d=3 len=1", out_data, out_len);
    end
    ack();
    vecs++;
    if ({out_data12, out_len12, overflow12, out_signed12} !== {exp12, 5'd1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL f12_requant: got d=%0d len=%0d ov=%b s=%b required d=%0d len=1 ov=0 s=0", out_data12, out_len12, overflow12, out_signed12, exp12);
    end
  endtask

  task automatic test_backpressure_reset();
    send(16'h3000, 1'b1, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if ({out_valid, out_data, in_ready, overflow} !== {1'b1, 16'h3000, 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL hold_%0d: got v=%b d=%h rdy=%b ov=%b required v=1 d=3000 rdy=0 ov=0", i, out_valid, out_data, in_ready, overflow);
      end
    end
    ack();
    send(16'd5000, 1'b1, 1'b0);
    send(16'd6000, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 0;
    #1;
    vecs++;
    if ({out_valid, out_data, out_len, overflow, out_signed} !== {1'b0, 16'h0, 5'd0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL midblock_reset: got v=%b d=%h len=%0d ov=%b s=%b required all 0", out_valid, out_data, out_len, overflow, out_signed);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_ready: got %b required 1", in_ready); end
    send(16'd8192, 1'b0, 1'b0);
    send(16'd8192, 1'b0, 1'b1);
    wait_valid();
    vecs++;
    if ({out_valid, out_data, out_len, overflow, out_signed} !== {1'b1, 16'd16384, 5'd2, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL after_reset_sum: got v=%b d=%0d len=%0d ov=%b s=%b required v=1 d=16384 len=2 ov=0 s=0", out_valid, out_data, out_len, overflow, out_signed);
    end
    ack();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_unsigned();
    test_signed_sat();
    test_unsigned_sat();
    test_len_cap();
    test_f_out12();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fp_accum.md
# fp_accum

Streaming fixed-point accumulator placed directly downstream of the fixed-point adder stage. It sums a block of Q(I_IN.F_IN) samples, signed or unsigned, into a guarded internal accumulator. It then requantises the sum to Q(I_OUT.F_OUT) with saturation and presents the result on a valid/ready output with an overflow flag. Blocks end on `in_last` or on a hard length cap that guarantees the accumulator itself never wraps.

## Interface
- `I_IN`, 2, integer bits of input samples
- `F_IN`, 14, fractional bits of input samples
- `I_OUT`, 2, integer bits of result
- `F_OUT`, 14, fractional bits of result
- `GUARD`, 4, accumulator guard bits; block length cap is 2^GUARD samples
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_data`  in  I_IN+F_IN  sample, two's complement if `in_signed`, else unsigned
- `in_signed`  in  1  block signedness, sampled on the first beat of a block
- `in_valid`  in  1  sample valid
- `in_last`  in  1  marks final sample of block
- `in_ready`  out  1  block accepts a sample
- `out_data`  out  I_OUT+F_OUT  requantised, saturated block sum
- `out_signed`  out  1  signedness of `out_data`
- `out_len`  out  GUARD+1  number of samples in the block
- `overflow`  out  1  saturation occurred in requantisation
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result

## Operation
- Accumulator width ACC_W = I_IN+F_IN+GUARD+1, scale F_IN. Signed samples are sign-extended. Unsigned samples are zero-extended.
- States are ACC, CONV and OUT. Reset enters ACC with acc=0, count=0, and all outputs 0 except `in_ready`.
- In state ACC, `in_ready`=1. On each beat where `in_valid` and `in_ready` are both high:
  - acc <= acc + sample; count++.
  - On the first beat of a block, acc <= sample and `in_signed` is latched. `in_signed` on later beats is ignored.
- The block closes on a beat with `in_last`=1, or on the beat where count reaches 2^GUARD. Closing moves the FSM to CONV. After a length-cap close, the next beat starts a new block.
- In CONV, `in_ready`=0 and the result is computed and registered:
  - Scale: if F_OUT >= F_IN, shift left by F_OUT-F_IN (exact). Otherwise shift right arithmetically by F_IN-F_OUT, applying the rounding rule in Configuration.
  - Saturate, signed: clamp to [-2^(I_OUT+F_OUT-1), 2^(I_OUT+F_OUT-1)-1].
  - Saturate, unsigned: clamp to [0, 2^(I_OUT+F_OUT)-1].
  - `overflow`=1 if and only if the clamp changed the value.
  - Register `out_data`, `out_signed`, `out_len`=count and `overflow`. Go to OUT.
- In OUT, `out_valid`=1 and `in_ready`=0. All outputs are held stable until `out_ready`=1. On that handshake edge: `out_valid` goes to 0, acc and count clear, and the FSM returns to ACC.
- `out_data`, `out_len` and `overflow` keep their last values after the handshake. Sinks qualify them with `out_valid`.

## Timing
- The last beat is accepted at edge E. The FSM is in CONV during the cycle after E. `out_valid` is high after edge E+1.
- With `out_ready` tied high, `in_ready` is low for exactly 2 cycles between blocks. Peak throughput is one sample per cycle within a block.
- `in_ready` depends only on state (registered), with no combinational path from `out_ready`.
- `rst_n` low at any point, including mid-block or in OUT, immediately:
  - discards the partial block;
  - forces `out_valid`=0, `out_data`=0, `out_len`=0, `overflow`=0, `out_signed`=0;
  - sets state to ACC.

  `in_ready` reads 1 from the first cycle after deassertion.
- The accumulator cannot overflow: 2^GUARD samples times the input range fits in ACC_W.

## Configuration
- Macro `FP_ACCUM_ROUND_EN` controls rounding on right shifts only.
- Defined: round half up, i.e. add 2^(F_IN-F_OUT-1) before the arithmetic right shift, then saturate. Saturation covers any carry that rounding produces.
- Undefined: truncate toward negative infinity (plain arithmetic right shift).

## Test plan
- Unsigned, defaults: 4 beats of 4096 (0.25), `in_last` on the 4th -> `out_data`=16384 (1.0), `out_len`=4, `overflow`=0, `out_valid` high after the edge following the last beat.
- Signed: -24576 (-1.5) then -16384 (-1.0, last) -> `out_data`=0x8000 (-2.0), `overflow`=1, `out_signed`=1.
- Unsigned: 3 beats of 24576 (1.5) -> `out_data`=0xFFFF, `overflow`=1.
- Length cap: 17 signed beats of value 1, `in_last` never set -> first result has `out_data`=16 and `out_len`=16. The 17th beat opens a new block.
- F_OUT=12, unsigned single beat 3 with last:
  - with `FP_ACCUM_ROUND_EN`: `out_data`=1;
  - without: `out_data`=0.
- Backpressure and reset: hold `out_ready`=0 for 5 cycles -> `out_data` stable and `in_ready`=0 throughout. Drop `rst_n` after 2 beats of the next block -> all outputs 0. A following block of 2 x 8192 gives 16384.
